// File: rtl/wb_pkg.sv
// wb_pkg: shared types and sizes for the register-file write-back path.
//   XLEN, AW, NREGS : data width, register address width, register count.
//   wb_entry_t      : one queued write (destination register + result data).
package wb_pkg;
  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int NREGS = 32;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of wb_entry_t used to buffer accepted results.
// Ports:
//   clk, rst         clock, asynchronous active-high reset (empties the FIFO)
//   push, push_entry write an entry (ignored when full)
//   pop              drop the head entry (ignored when empty)
//   full, empty      occupancy flags, derived from registered pointers only
//   head             oldest entry, read straight from storage
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);
  localparam int PW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0] rd_ptr_q, rd_ptr_d;
  wb_entry_t   mem_q [DEPTH];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full)  wr_ptr_d = wr_ptr_q + (PW+1)'(1);
    if (pop  && !empty) rd_ptr_d = rd_ptr_q + (PW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state flops use non-blocking assignments so all flops update together at the edge.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_ptr_q[PW-1:0]] <= push_entry;
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign head  = mem_q[rd_ptr_q[PW-1:0]];
endmodule

// File: rtl/reg_wb_ctrl.sv
// reg_wb_ctrl: write-side controller of the 32x32 register file.
// Accepts results from the load unit (priority) and the ALU over valid/ready,
// buffers them in wb_fifo and retires one register-file write per cycle.
// A per-register busy mask lets decode stall on RAW/WAW hazards.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   ld_valid/ready/addr/data          load-unit result handshake
//   alu_valid/ready/addr/data         ALU result handshake
//   we, w_addr, w_data                register-file write port
//   iss_valid, iss_addr, iss_ready    decode issue (marks destination busy)
//   q_addr1/2, q_busy1/2              source-operand busy queries
// Build option: define WB_BYPASS_EN to let a result accepted into an empty
// FIFO drive the write port combinationally in the same cycle.
module reg_wb_ctrl
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = wb_pkg::XLEN,
  parameter int AW    = wb_pkg::AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [AW-1:0]   ld_addr,
  input  logic [XLEN-1:0] ld_data,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_addr,
  input  logic [XLEN-1:0] alu_data,
  output logic            we,
  output logic [AW-1:0]   w_addr,
  output logic [XLEN-1:0] w_data,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_addr,
  output logic            iss_ready,
  input  logic [AW-1:0]   q_addr1,
  input  logic [AW-1:0]   q_addr2,
  output logic            q_busy1,
  output logic            q_busy2
);
  localparam int NR = 1 << AW;

  wb_entry_t       push_entry;
  wb_entry_t       head;
  logic            full, empty;
  logic            ld_fire, alu_fire, push_valid, fifo_push;
  logic [NR-1:0]   busy_q, busy_d;

  // Ready depends only on occupancy (and ld_valid for the ALU), never on data.
  assign ld_ready  = !full;
  assign alu_ready = !full && !ld_valid;
  assign ld_fire   = ld_valid  && ld_ready;
  assign alu_fire  = alu_valid && alu_ready;

  // Results to x0 complete the handshake but are dropped here.
  assign push_entry = ld_fire ? wb_entry_t'({ld_addr, ld_data})
                              : wb_entry_t'({alu_addr, alu_data});
  assign push_valid = (ld_fire || alu_fire) && (push_entry.addr != '0);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (we),
    .full       (full),
    .empty      (empty),
    .head       (head)
  );

  // Write port comes from the FIFO head; zeroed when empty so reset shows 0s.
  always_comb begin
    we        = 1'b0;
    w_addr    = '0;
    w_data    = '0;
    fifo_push = push_valid;
    if (!empty) begin
      we     = 1'b1;
      w_addr = head.addr;
      w_data = head.data;
    end
`ifdef WB_BYPASS_EN
    // Empty FIFO: the accepted result goes straight to the register file
    // and is not enqueued. Gated by rst so nothing writes during reset.
    else if (push_valid && !rst) begin
      we        = 1'b1;
      w_addr    = push_entry.addr;
      w_data    = push_entry.data;
      fifo_push = 1'b0;
    end
`endif
  end

  // Busy mask: clear on write, set on issue; set is applied last so it wins.
  always_comb begin
    busy_d = busy_q;
    if (we) busy_d[w_addr] = 1'b0;
    if (iss_valid && iss_ready && (iss_addr != '0)) busy_d[iss_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign iss_ready = !busy_q[iss_addr];
  assign q_busy1   = busy_q[q_addr1];
  assign q_busy2   = busy_q[q_addr2];
endmodule

// File: tb/tb_reg_wb_ctrl.sv
// tb_reg_wb_ctrl: directed test of reg_wb_ctrl. A per-cycle driver task
// predicts ready/we/busy from a small occupancy and busy model and pushes
// every accepted non-x0 result into an expected-write queue; an independent
// monitor pops that queue whenever the DUT asserts we and compares the write.
module tb_reg_wb_ctrl;
  import wb_pkg::*;

  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ld_valid = 1'b0, alu_valid = 1'b0, iss_valid = 1'b0;
  logic [AW-1:0]   ld_addr = '0, alu_addr = '0, iss_addr = '0;
  logic [AW-1:0]   q_addr1 = '0, q_addr2 = '0;
  logic [XLEN-1:0] ld_data = '0, alu_data = '0;
  logic            ld_ready, alu_ready, we, iss_ready, q_busy1, q_busy2;
  logic [AW-1:0]   w_addr;
  logic [XLEN-1:0] w_data;

  int              n_vec = 0;
  int              n_err = 0;
  wb_entry_t       exp_q[$];
  int              mcount = 0;
  logic [NREGS-1:0] mbusy = '0;

  reg_wb_ctrl #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .we        (we),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready),
    .q_addr1   (q_addr1),
    .q_addr2   (q_addr2),
    .q_busy1   (q_busy1),
    .q_busy2   (q_busy2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every DUT write must match the oldest expected write.
  always @(negedge clk) begin
    wb_entry_t e;
    #2;
    if (!rst && we) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got addr=%0d data=%h expected no write", w_addr, w_data);
      end else begin
        e = exp_q.pop_front();
        check("w_addr", 32'(w_addr), 32'(e.addr));
        check("w_data", w_data, e.data);
      end
    end
  end

  // One clock of stimulus: inputs are already set (posedge+1). Checks the
  // handshake/busy outputs at negedge against the model, then steps the model.
  task automatic cycle();
    logic      exp_ld_rdy, exp_alu_rdy, ld_f, alu_f, push_en, wr_v, iss_f;
    logic [AW-1:0] wr_a;
    wb_entry_t pe;
    @(negedge clk);
    exp_ld_rdy  = (mcount < DEPTH);
    exp_alu_rdy = exp_ld_rdy && !ld_valid;
    check("ld_ready",  32'(ld_ready),  32'(exp_ld_rdy));
    check("alu_ready", 32'(alu_ready), 32'(exp_alu_rdy));
    ld_f    = ld_valid && exp_ld_rdy;
    alu_f   = alu_valid && exp_alu_rdy;
    pe      = ld_f ? wb_entry_t'({ld_addr, ld_data}) : wb_entry_t'({alu_addr, alu_data});
    push_en = (ld_f || alu_f) && (pe.addr != '0);
    wr_v    = 1'b0;
    wr_a    = '0;
    if (mcount > 0) begin
      wr_v = 1'b1;
      wr_a = exp_q[0].addr;
    end
`ifdef WB_BYPASS_EN
    else if (push_en) begin
      wr_v = 1'b1;
      wr_a = pe.addr;
    end
`endif
    check("we",        32'(we),        32'(wr_v));
    check("iss_ready", 32'(iss_ready), 32'(!mbusy[iss_addr]));
    check("q_busy1",   32'(q_busy1),   32'(mbusy[q_addr1]));
    check("q_busy2",   32'(q_busy2),   32'(mbusy[q_addr2]));
    iss_f = iss_valid && !mbusy[iss_addr] && (iss_addr != '0);
    if (push_en) exp_q.push_back(pe);
    @(posedge clk);
    if (wr_v)  mbusy[wr_a] = 1'b0;
    if (iss_f) mbusy[iss_addr] = 1'b1;
`ifdef WB_BYPASS_EN
    if (!(mcount == 0 && push_en))
`endif
      mcount = mcount + (push_en ? 1 : 0) - ((mcount > 0) ? 1 : 0);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    #1;
    check("rst_we",        32'(we),        32'd0);
    check("rst_w_addr",    32'(w_addr),    32'd0);
    check("rst_w_data",    w_data,         32'd0);
    check("rst_ld_ready",  32'(ld_ready),  32'd1);
    check("rst_alu_ready", 32'(alu_ready), 32'd1);
    check("rst_iss_ready", 32'(iss_ready), 32'd1);
    check("rst_q_busy1",   32'(q_busy1),   32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single ALU push r5.
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
    cycle();
    alu_valid = 1'b0;
    cycle();
    cycle();

    // Load and ALU together: load first, ALU next cycle.
    ld_valid = 1'b1; ld_addr = 5'd3; ld_data = 32'h11;
    alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'h22;
    cycle();
    ld_valid = 1'b0;
    cycle();
    alu_valid = 1'b0;
    cycle();
    cycle();

    // Six back-to-back loads.
    for (int i = 0; i < 6; i++) begin
      ld_valid = 1'b1; ld_addr = AW'(16 + i); ld_data = 32'hA000_0000 + 32'(i);
      cycle();
    end
    ld_valid = 1'b0;
    cycle();
    cycle();

    // Result to x0: handshake only, no write.
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hFFFFFFFF;
    cycle();
    alu_valid = 1'b0;
    cycle();

    // Scoreboard: issue r7, stall a second issue, clear on retirement.
    iss_valid = 1'b1; iss_addr = 5'd7; q_addr1 = 5'd7;
    cycle();
    cycle();
    check("busy7_set", 32'(q_busy1), 32'd1);
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h77;
    cycle();
    alu_valid = 1'b0;
    cycle();
    cycle();
    check("busy7_clear",   32'(q_busy1),   32'd0);
    check("iss7_ready",    32'(iss_ready), 32'd1);

    // Issue to r9 in the same cycle as the r9 write: set wins.
    q_addr2 = 5'd9;
    alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h99;
`ifdef WB_BYPASS_EN
    iss_valid = 1'b1; iss_addr = 5'd9;
    cycle();
    alu_valid = 1'b0;
`else
    cycle();
    alu_valid = 1'b0;
    iss_valid = 1'b1; iss_addr = 5'd9;
    cycle();
`endif
    iss_valid = 1'b0;
    cycle();
    check("busy9_set_wins", 32'(q_busy2), 32'd1);

    // Mid-cycle reset with busy bits set and a write pending.
    for (int i = 10; i < 13; i++) begin
      iss_valid = 1'b1; iss_addr = AW'(i);
      cycle();
    end
    iss_valid = 1'b0;
    q_addr1 = 5'd10; q_addr2 = 5'd11;
    ld_valid = 1'b1; ld_addr = 5'd10; ld_data = 32'hCAFE0010;
    cycle();
    ld_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_we",        32'(we),        32'd0);
    check("arst_w_addr",    32'(w_addr),    32'd0);
    check("arst_q_busy1",   32'(q_busy1),   32'd0);
    check("arst_q_busy2",   32'(q_busy2),   32'd0);
    check("arst_iss_ready", 32'(iss_ready), 32'd1);
    check("arst_ld_ready",  32'(ld_ready),  32'd1);
    exp_q.delete();
    mcount = 0;
    mbusy  = '0;
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) cycle();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
